ir_queue: RTL and testbench

IR_QUEUE -- requirements
Module: ir_queue

---
 rtl/ir_pkg.sv | 11 +
 rtl/ir_queue_mem.sv | 22 ++
 rtl/ir_queue.sv | 85 ++++++++
 tb/tb_ir_queue.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/ir_pkg.sv
// Shared constants for the instruction queue: default geometry and error-flag indices.
package ir_pkg;
   localparam int IR_WIDTH = 18;
   localparam int IR_DEPTH = 4;
   localparam int IR_OPC_W = 5;

   // Bit positions inside the sticky error vector
   localparam int ERR_OVF = 0;
   localparam int ERR_UDF = 1;
   localparam int ERR_NUM = 2;
endpackage

// File: rtl/ir_queue_mem.sv
// Queue storage: one synchronous write port, one combinational read port, no reset.
module ir_queue_mem #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 4,
   parameter int PW    = 2
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];

   // Write the tail entry; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/ir_queue.sv
// Instruction queue: FIFO of instruction words with a registered output stage,
// sticky overflow/underflow flags and a flush that empties the queue.
module ir_queue
   import ir_pkg::*;
#(
   parameter int WIDTH = IR_WIDTH,
   parameter int DEPTH = IR_DEPTH,
   parameter int OPC_W = IR_OPC_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_IR,
   input  logic [WIDTH-1:0]           ir_in,
   input  logic                       re_IR,
   input  logic                       flush,
   output logic [WIDTH-1:0]           ir_out,
   output logic                       ir_valid,
   output logic [OPC_W-1:0]           opcode,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       ovf_err,
   output logic                       udf_err
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0]      wr_ptr, rd_ptr;
   logic [WIDTH-1:0]   head;
   logic [ERR_NUM-1:0] err;
   logic               pop_ok, push_ok, mem_we;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // A pop frees the head slot on the same edge, so a full queue may still accept a push
   assign pop_ok  = re_IR && !empty;
   assign push_ok = wr_IR && (!full || pop_ok);
   assign mem_we  = push_ok && !flush && !rst;

   ir_queue_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PW(PW)) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wr_ptr),
      .wdata (ir_in),
      .raddr (rd_ptr),
      .rdata (head)
   );

   // Pointers, occupancy, output register and sticky error flags
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         ir_out   <= '0;
         ir_valid <= 1'b0;
         err      <= '0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         ir_out   <= '0;
         ir_valid <= 1'b0;
      end else begin
         ir_valid <= pop_ok;
         if (pop_ok) begin
            ir_out <= head;
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (wr_IR && full && !pop_ok) err[ERR_OVF] <= 1'b1;
         if (re_IR && empty)           err[ERR_UDF] <= 1'b1;
      end
   end

   assign ovf_err = err[ERR_OVF];
   assign udf_err = err[ERR_UDF];
   assign opcode  = ir_out[WIDTH-1 -: OPC_W];
endmodule

// File: tb/tb_ir_queue.sv
// Directed self-checking bench for ir_queue at default parameters (18-bit words, 4 entries).
module tb_ir_queue;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr_IR = 1'b0;
   logic [17:0] ir_in = '0;
   logic        re_IR = 1'b0;
   logic        flush = 1'b0;
   logic [17:0] ir_out;
   logic        ir_valid;
   logic [4:0]  opcode;
   logic        full, empty;
   logic [2:0]  count;
   logic        ovf_err, udf_err;

   int n_cmp = 0;
   int n_err = 0;

   ir_queue dut (
      .clk(clk), .rst(rst), .wr_IR(wr_IR), .ir_in(ir_in), .re_IR(re_IR), .flush(flush),
      .ir_out(ir_out), .ir_valid(ir_valid), .opcode(opcode), .full(full), .empty(empty),
      .count(count), .ovf_err(ovf_err), .udf_err(udf_err)
   );

   always #5 clk = ~clk;

   // Apply one cycle of inputs, then sample 1 ns after the rising edge
   task automatic step(input logic r, input logic w, input logic [17:0] d,
                       input logic p, input logic f);
      rst = r; wr_IR = w; ir_in = d; re_IR = p; flush = f;
      @(posedge clk); #1;
      rst = 1'b0; wr_IR = 1'b0; re_IR = 1'b0; flush = 1'b0;
   endtask

   task automatic test_reset;
      step(1, 1, 18'h2AAAA, 1, 0);
      n_cmp++; if (ir_out !== 18'h0) begin n_err++; $display("FAIL reset_ir_out got %h want %h", ir_out, 18'h0); end
      n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL reset_ir_valid got %b want 0", ir_valid); end
      n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b want 1", empty); end
      n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b want 0", full); end
      n_cmp++; if (ovf_err !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf_err); end
      n_cmp++; if (udf_err !== 1'b0) begin n_err++; $display("FAIL reset_udf got %b want 0", udf_err); end
   endtask

   task automatic test_fifo_order;
      logic [17:0] exp_v [3];
      exp_v = '{18'h00001, 18'h00002, 18'h00003};
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, exp_v[i], 0, 0);
      n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL order_count got %0d want 3", count); end
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 1, 0);
         n_cmp++; if (ir_out !== exp_v[i]) begin n_err++; $display("FAIL order_pop%0d got %h want %h", i, ir_out, exp_v[i]); end
         n_cmp++; if (ir_valid !== 1'b1) begin n_err++; $display("FAIL order_valid%0d got %b want 1", i, ir_valid); end
      end
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL order_empty got %b want 1", empty); end
      step(0, 0, 0, 0, 0);
      n_cmp++; if (ir_valid !== 1'b0 || ir_out !== 18'h00003) begin n_err++; $display("FAIL order_idle got %b/%h want 0/00003", ir_valid, ir_out); end
   endtask

   task automatic test_overflow;
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 18'h10 + 18'(i), 0, 0);
         n_cmp++; if (full !== (i == 3)) begin n_err++; $display("FAIL ovf_full%0d got %b want %b", i, full, (i == 3)); end
      end
      n_cmp++; if (ovf_err !== 1'b0) begin n_err++; $display("FAIL ovf_early got %b want 0", ovf_err); end
      step(0, 1, 18'h14, 0, 0);
      n_cmp++; if (ovf_err !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b want 1", ovf_err); end
      n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL ovf_count got %0d want 4", count); end
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 1, 0);
         n_cmp++; if (ir_out !== 18'h10 + 18'(i)) begin n_err++; $display("FAIL ovf_pop%0d got %h want %h", i, ir_out, 18'h10 + 18'(i)); end
      end
      n_cmp++; if (empty !== 1'b1 || udf_err !== 1'b0) begin n_err++; $display("FAIL ovf_end empty/udf got %b/%b want 1/0", empty, udf_err); end
   endtask

   task automatic test_underflow;
      // Queue is empty with ir_out = 0x13 from the previous scenario
      step(0, 0, 0, 1, 0);
      n_cmp++; if (ir_out !== 18'h13) begin n_err++; $display("FAIL udf_hold got %h want %h", ir_out, 18'h13); end
      n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL udf_valid got %b want 0", ir_valid); end
      n_cmp++; if (udf_err !== 1'b1) begin n_err++; $display("FAIL udf_flag got %b want 1", udf_err); end
      n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL udf_count got %0d want 0", count); end
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
      n_cmp++; if (udf_err !== 1'b1) begin n_err++; $display("FAIL udf_sticky got %b want 1", udf_err); end
      n_cmp++; if (ovf_err !== 1'b1) begin n_err++; $display("FAIL udf_ovf_sticky got %b want 1", ovf_err); end
   endtask

   task automatic test_full_push_pop;
      logic [17:0] exp_v [4];
      exp_v = '{18'h21, 18'h22, 18'h23, 18'h3FFFF};
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 18'h20 + 18'(i), 0, 0);
      step(0, 1, 18'h3FFFF, 1, 0);
      n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL fpp_count got %0d want 4", count); end
      n_cmp++; if (ir_out !== 18'h20) begin n_err++; $display("FAIL fpp_head got %h want %h", ir_out, 18'h20); end
      n_cmp++; if (ovf_err !== 1'b0) begin n_err++; $display("FAIL fpp_ovf got %b want 0", ovf_err); end
      n_cmp++; if (opcode !== 5'h00) begin n_err++; $display("FAIL fpp_opc0 got %h want 00", opcode); end
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 1, 0);
         n_cmp++; if (ir_out !== exp_v[i]) begin n_err++; $display("FAIL fpp_pop%0d got %h want %h", i, ir_out, exp_v[i]); end
      end
      n_cmp++; if (opcode !== 5'h1F) begin n_err++; $display("FAIL fpp_opcode got %h want 1f", opcode); end
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL fpp_empty got %b want 1", empty); end
   endtask

   task automatic test_flush;
      step(1, 0, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 18'h31 + 18'(i), 0, 0);
      step(0, 0, 0, 1, 0);
      n_cmp++; if (count !== 3'd3 || ir_out !== 18'h31) begin n_err++; $display("FAIL fl_pre got %0d/%h want 3/00031", count, ir_out); end
      step(0, 1, 18'h2ABCD, 1, 1);
      n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL fl_count got %0d want 0", count); end
      n_cmp++; if (ir_out !== 18'h0) begin n_err++; $display("FAIL fl_ir_out got %h want 0", ir_out); end
      n_cmp++; if (ir_valid !== 1'b0) begin n_err++; $display("FAIL fl_valid got %b want 0", ir_valid); end
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL fl_empty got %b want 1", empty); end
      n_cmp++; if (udf_err !== 1'b1 || ovf_err !== 1'b0) begin n_err++; $display("FAIL fl_flags got %b/%b want 1/0", udf_err, ovf_err); end
      step(0, 1, 18'h55, 0, 0);
      step(0, 0, 0, 1, 0);
      n_cmp++; if (ir_out !== 18'h55 || ir_valid !== 1'b1) begin n_err++; $display("FAIL fl_after got %h/%b want 00055/1", ir_out, ir_valid); end
      n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL fl_after_empty got %b want 1", empty); end
   endtask

   task automatic test_wrap_and_reset;
      step(1, 0, 0, 0, 0);
      step(0, 1, 18'h100, 0, 0);
      for (int i = 1; i <= 12; i++) begin
         step(0, 1, 18'h100 + 18'(i), 1, 0);
         n_cmp++; if (ir_out !== 18'h100 + 18'(i - 1) || ir_valid !== 1'b1) begin
            n_err++; $display("FAIL wrap%0d got %h/%b want %h/1", i, ir_out, ir_valid, 18'h100 + 18'(i - 1));
         end
      end
      n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL wrap_count got %0d want 1", count); end
      step(0, 1, 18'h200, 0, 0);
      step(1, 1, 18'h300, 1, 0);
      n_cmp++; if (ir_out !== 18'h0 || ir_valid !== 1'b0) begin n_err++; $display("FAIL mrst_out got %h/%b want 0/0", ir_out, ir_valid); end
      n_cmp++; if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL mrst_occ got %0d/%b/%b want 0/1/0", count, empty, full); end
      n_cmp++; if (ovf_err !== 1'b0 || udf_err !== 1'b0) begin n_err++; $display("FAIL mrst_flags got %b/%b want 0/0", ovf_err, udf_err); end
      step(0, 0, 0, 1, 0);
      n_cmp++; if (udf_err !== 1'b1 || ir_valid !== 1'b0 || ir_out !== 18'h0) begin
         n_err++; $display("FAIL mrst_udf got %b/%b/%h want 1/0/0", udf_err, ir_valid, ir_out);
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_fifo_order();
      test_overflow();
      test_underflow();
      test_full_push_pop();
      test_flush();
      test_wrap_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
